arb_requester: RTL

//   Requester-side agent for the two-input round arbiter: issues a request on a

---
 rtl/arb_requester.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for the two-input arbiter.
// Raises req on an accepted start, owns the resource for len beats once
// granted, re-requests after preemption, and backs off / retries when the
// grant does not arrive in time. All outputs are registered.
module arb_requester #(
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 8,
  parameter int BACKOFF   = 3,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             own,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int BW = $clog2(BACKOFF + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OWN  = 2'd2,
    S_BACK = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;    // beats still to transfer
  logic [WW-1:0]    wcnt;   // cycles spent in REQ without grant
  logic [BW-1:0]    bcnt;   // cycles spent in BACK
  logic [RW-1:0]    retry;  // timeouts already taken in this burst

  // Single FSM: state, counters and every output registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rem     <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      retry   <= '0;
      req     <= 1'b0;
      own     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      // status outputs are single-cycle pulses
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state <= S_REQ;
              req   <= 1'b1;
              busy  <= 1'b1;
              rem   <= len;
              wcnt  <= '0;
              retry <= '0;
            end else begin
              // zero-length burst completes immediately without arbitration
              done <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (gnt) begin
            // a grant on the expiring cycle still wins
            state <= S_OWN;
            own   <= 1'b1;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            req <= 1'b0;
            if (retry == RW'(MAX_RETRY)) begin
              // final expiry reports err alone so done/timeout/err never overlap
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              timeout <= 1'b1;
              retry   <= retry + RW'(1);
              bcnt    <= '0;
              state   <= S_BACK;
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end

        S_OWN: begin
          // every cycle with own=1 is a transferred beat
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state <= S_IDLE;
            req   <= 1'b0;
            own   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!gnt) begin
            // preempted: stop owning next cycle, keep requesting
            state <= S_REQ;
            own   <= 1'b0;
            wcnt  <= '0;
          end
        end

        S_BACK: begin
          // the timeout cycle itself is the first low cycle of the backoff
          if (bcnt == BW'(BACKOFF - 1)) begin
            state <= S_REQ;
            req   <= 1'b1;
            wcnt  <= '0;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
